// File: rtl/gayle_pkg.sv
// Shared sector-reader types and constants.
// Used by gayle_sector_reader and gayle_cksum16.
package gayle_pkg;

    localparam int GAYLE_SECTOR_WORDS = 256;
    localparam int GAYLE_FETCH_CYCLES = 2;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_FULL,
        FETCH,
        SEND_HI,
        SEND_LO,
        POP,
        CK_HI,
        CK_LO,
        DONE
    } state_t;

endpackage

// File: rtl/gayle_sector_reader_if.sv
// FIFO read port and host byte stream of the sector reader.
// master = reader side, slave = FIFO/host side.
interface gayle_sector_reader_if;

    logic [15:0] fifo_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_last;
    logic        fifo_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  fifo_data, fifo_full, fifo_empty, fifo_last, tx_ready,
        output fifo_rd, tx_data, tx_valid
    );

    modport slave (
        output fifo_data, fifo_full, fifo_empty, fifo_last, tx_ready,
        input  fifo_rd, tx_data, tx_valid
    );

endinterface

// File: rtl/gayle_cksum16.sv
// 16-bit modular sum of the sector words (clear / add).
// Only instantiated when GAYLE_SECTOR_CKSUM_EN is defined.
module gayle_cksum16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        clear,
    input  logic        add,
    input  logic [15:0] data,
    output logic [15:0] sum
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (en) begin
            if (clear)
                sum <= '0;
            else if (add)
                sum <= sum + data;
        end
    end

endmodule

// File: rtl/gayle_sector_reader.sv
// Streams one 256-word sector from the FIFO to the host, high byte first.
// Define GAYLE_SECTOR_CKSUM_EN to append a 16-bit checksum (514 bytes).
module gayle_sector_reader
    import gayle_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clk7_en,
    input  logic start,
    input  logic abort,
    gayle_sector_reader_if.master bus,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [7:0] LAST_WORD  = 8'(GAYLE_SECTOR_WORDS - 1);
    localparam logic [1:0] FETCH_LAST = 2'(GAYLE_FETCH_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  word_cnt, cnt_nx;
    logic [1:0]  fetch_cnt, fcnt_nx;
    logic [15:0] word, word_nx;
    logic        err_nx;
    logic        start_ok;
    logic        fetch_ok;
    logic [7:0]  tx_byte;

    assign start_ok = (state == IDLE) && start && !abort;
    assign fetch_ok = (state == FETCH) && !bus.fifo_empty &&
                      (fetch_cnt == FETCH_LAST) && !abort;

`ifdef GAYLE_SECTOR_CKSUM_EN
    logic [15:0] cksum;

    gayle_cksum16 u_cksum (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (clk7_en),
        .clear   (start_ok),
        .add     (fetch_ok),
        .data    (bus.fifo_data),
        .sum     (cksum)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            fetch_cnt <= '0;
            word      <= '0;
            err       <= 1'b0;
        end else if (clk7_en) begin
            state     <= state_nx;
            word_cnt  <= cnt_nx;
            fetch_cnt <= fcnt_nx;
            word      <= word_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = word_cnt;
        fcnt_nx  = fetch_cnt;
        word_nx  = word;
        err_nx   = err;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state_nx = WAIT_FULL;
                        cnt_nx   = '0;
                        err_nx   = 1'b0;
                    end
                end
                WAIT_FULL: begin
                    if (bus.fifo_full) begin
                        state_nx = FETCH;
                        fcnt_nx  = '0;
                    end
                end
                FETCH: begin
                    if (bus.fifo_empty) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end else if (fetch_ok) begin
                        word_nx  = bus.fifo_data;
                        state_nx = SEND_HI;
                    end else begin
                        fcnt_nx = fetch_cnt + 2'd1;
                    end
                end
                SEND_HI: if (bus.tx_ready) state_nx = SEND_LO;
                SEND_LO: if (bus.tx_ready) state_nx = POP;
                POP: begin
                    cnt_nx = word_cnt + 8'd1;
                    if (word_cnt == LAST_WORD) begin
                        if (!bus.fifo_last)
                            err_nx = 1'b1;
`ifdef GAYLE_SECTOR_CKSUM_EN
                        state_nx = CK_HI;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        state_nx = FETCH;
                        fcnt_nx  = '0;
                    end
                end
`ifdef GAYLE_SECTOR_CKSUM_EN
                CK_HI: if (bus.tx_ready) state_nx = CK_LO;
                CK_LO: if (bus.tx_ready) state_nx = DONE;
`endif
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        unique case (state)
            SEND_HI: tx_byte = word[15:8];
            SEND_LO: tx_byte = word[7:0];
`ifdef GAYLE_SECTOR_CKSUM_EN
            CK_HI:   tx_byte = cksum[15:8];
            CK_LO:   tx_byte = cksum[7:0];
`endif
            default: tx_byte = 8'h00;
        endcase
    end

    // Pop is suppressed on an abort edge so the FIFO never loses a word.
    assign bus.fifo_rd  = (state == POP) && !abort;
    assign bus.tx_valid = state inside {SEND_HI, SEND_LO, CK_HI, CK_LO};
    assign bus.tx_data  = tx_byte;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_gayle_sector_reader.sv
// Directed bench for gayle_sector_reader with a behavioural FIFO.
// Build with GAYLE_SECTOR_CKSUM_EN to check the checksum variant.
module tb_gayle_sector_reader;

`ifdef GAYLE_SECTOR_CKSUM_EN
    localparam int NB = 514;
`else
    localparam int NB = 512;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk7_en = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic tx_ready = 1'b0;
    logic busy, done, err;

    gayle_sector_reader_if bus();

    gayle_sector_reader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk7_en (clk7_en),
        .start   (start),
        .abort   (abort),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1023];
    logic [15:0] fifo_data_r = 16'h0;
    logic [7:0]  bytes_q [0:1023];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int pops = 0;
    int nbytes = 0;
    int dones = 0;
    int stall_bad = 0;
    logic stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h0;
    logic tb_clr = 1'b0;
    logic empty_ovr = 1'b0;
    logic last_kill = 1'b0;
    int checks = 0;
    int errors = 0;

    assign bus.fifo_data  = fifo_data_r;
    assign bus.fifo_full  = (wr_cnt - rd_cnt) >= 256;
    assign bus.fifo_empty = ((wr_cnt - rd_cnt) <= 0) || empty_ovr;
    assign bus.fifo_last  = ((rd_cnt % 256) == 255) && !last_kill;
    assign bus.tx_ready   = tx_ready;

    always @(posedge clk) begin
        if (tb_clr) begin
            rd_cnt <= 0;
            pops   <= 0;
            nbytes <= 0;
            dones  <= 0;
        end else if (clk7_en) begin
            if (bus.fifo_rd) begin
                rd_cnt <= rd_cnt + 1;
                pops   <= pops + 1;
            end
            fifo_data_r <= mem[rd_cnt & 1023];
            if (bus.tx_valid && bus.tx_ready && nbytes < 1024) begin
                bytes_q[nbytes] <= bus.tx_data;
                nbytes <= nbytes + 1;
            end
            if (done)
                dones <= dones + 1;
        end
    end

    always @(posedge clk) begin
        if (tb_clr)
            stall_bad <= 0;
        else if (stall_prev && bus.tx_valid && bus.tx_data !== stall_data)
            stall_bad <= stall_bad + 1;
        stall_prev <= bus.tx_valid && !(bus.tx_ready && clk7_en) &&
                      reset_n && !abort;
        stall_data <= bus.tx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input bit ones, input int i);
        logic [15:0] w;
        if (i < 512) begin
            w = ones ? 16'h0101 : 16'(i / 2);
            return (i % 2) ? w[7:0] : w[15:8];
        end
        w = ones ? 16'h0100 : 16'h7f80;
        return (i == 512) ? w[15:8] : w[7:0];
    endfunction

    task automatic check_bytes(input string tag, input int n, input bit ones);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (bytes_q[i] !== exp_byte(ones, i))
                bad++;
        check(tag, bad, 0);
    endtask

    task automatic clr();
        @(negedge clk);
        tb_clr = 1'b1;
        wr_cnt = 0;
        empty_ovr = 1'b0;
        last_kill = 1'b0;
        clk7_en = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
    endtask

    task automatic load(input int n, input bit ones);
        for (int i = 0; i < n; i++) begin
            mem[wr_cnt & 1023] = ones ? 16'h0101 : 16'(wr_cnt);
            wr_cnt++;
        end
    endtask

    task automatic run(input bit do_start, input bit rnd, input int abort_at,
                       input int empty_at, input int reset_at,
                       input int budget, output bit fin);
        int c;
        fin = 1'b0;
        if (do_start) begin
            start = 1'b1;
            clk7_en = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (c = 0; c < budget; c++) begin
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            if (abort_at >= 0 && pops == abort_at) begin
                abort = 1'b1;
                clk7_en = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_idle", busy, 0);
                check("abort_txv", bus.tx_valid, 0);
                fin = 1'b1;
                break;
            end
            if (reset_at >= 0 && pops == reset_at) begin
                reset_n = 1'b0;
                clk7_en = 1'b0;
                @(negedge clk);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_rd", bus.fifo_rd, 0);
                reset_n = 1'b1;
                fin = 1'b1;
                break;
            end
            if (empty_at >= 0 && pops >= empty_at)
                empty_ovr = 1'b1;
            if (rnd) begin
                tx_ready = 1'($urandom_range(0, 1));
                clk7_en = ($urandom_range(0, 3) == 0);
            end else begin
                tx_ready = 1'b1;
                clk7_en = 1'b1;
            end
            @(negedge clk);
        end
        clk7_en = 1'b1;
        tx_ready = 1'b1;
    endtask

    initial begin
        bit fin;
        // reset applies even with the clock enable low
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_txv", bus.tx_valid, 0);
        check("rst_txd", bus.tx_data, 0);
        check("rst_rd", bus.fifo_rd, 0);
        reset_n = 1'b1;

        clr();
        load(256, 0);
        run(1, 0, -1, -1, -1, 5000, fin);
        check("seq_fin", fin, 1);
        check("seq_nbytes", nbytes, NB);
        check_bytes("seq_bytes", NB, 0);
        check("seq_pops", pops, 256);
        check("seq_dones", dones, 1);
        check("seq_err", err, 0);

        clr();
        load(256, 0);
        run(1, 1, -1, -1, -1, 30000, fin);
        check("rnd_fin", fin, 1);
        check("rnd_nbytes", nbytes, NB);
        check_bytes("rnd_bytes", NB, 0);
        check("rnd_stall", stall_bad, 0);
        check("rnd_pops", pops, 256);
        check("rnd_dones", dones, 1);

        clr();
        load(255, 0);
        run(1, 0, -1, -1, -1, 40, fin);
        check("wf_wait", fin, 0);
        check("wf_busy", busy, 1);
        check("wf_pops", pops, 0);
        load(1, 0);
        run(0, 0, -1, -1, -1, 5000, fin);
        check("wf_fin", fin, 1);
        check("wf_nbytes", nbytes, NB);
        check("wf_dones", dones, 1);

        clr();
        load(256, 0);
        run(1, 0, 50, -1, -1, 5000, fin);
        repeat (10) @(negedge clk);
        check("ab_pops", pops, 50);
        check("ab_nbytes", nbytes, 100);
        check("ab_busy", busy, 0);
        check("ab_dones", dones, 0);

        clr();
        last_kill = 1'b1;
        load(256, 0);
        run(1, 0, -1, -1, -1, 5000, fin);
        check("lk_err", err, 1);
        check("lk_dones", dones, 1);
        check("lk_pops", pops, 256);

        clr();
        load(256, 0);
        run(1, 0, -1, 10, -1, 5000, fin);
        check("em_fin", fin, 1);
        check("em_err", err, 1);
        check("em_pops", pops, 10);
        check("em_dones", dones, 0);

        clr();
        load(256, 0);
        run(1, 0, -1, -1, 20, 5000, fin);
        repeat (20) @(negedge clk);
        check("rm_pops", pops, 20);
        check("rm_err", err, 0);
        check("rm_busy", busy, 0);

        clr();
        load(256, 1);
        run(1, 0, -1, -1, -1, 5000, fin);
        check("one_nbytes", nbytes, NB);
        check_bytes("one_bytes", NB, 1);
        check("one_dones", dones, 1);
        check("one_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gayle_sector_reader.md
GAYLE_SECTOR_READER -- requirements
Module: gayle_sector_reader

Interface
REQ-001 SHALL provide: clk  in  1  bus clock; all logic on rising edge.
REQ-002 SHALL provide: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL provide: clk7_en  in  1  clock enable; state, counters and outputs advance only on clk edges with clk7_en=1.
REQ-004 SHALL provide: start  in  1  host request to stream one sector.
REQ-005 SHALL provide: abort  in  1  cancel the current transfer.
REQ-006 SHALL provide: fifo_data  in  16  FIFO read data; registered, updated one enabled edge after the read pointer moves.
REQ-007 SHALL provide: fifo_full, fifo_empty, fifo_last  in  1 each  FIFO status (>=256 words held / empty / read pointer at sector word 255).
REQ-008 SHALL provide: fifo_rd  out  1  FIFO pop strobe.
REQ-009 SHALL provide: tx_data  out  8, tx_valid  out  1, tx_ready  in  1  byte stream to host.
REQ-010 SHALL provide: busy  out  1, done  out  1, err  out  1  status.

Function
REQ-011 SHALL use states IDLE, WAIT_FULL, FETCH, SEND_HI, SEND_LO, POP, CK_HI, CK_LO, DONE.
REQ-012 IDLE: start=1 -> WAIT_FULL, clear word_cnt (8 bit) and err; start while not IDLE SHALL be ignored.
REQ-013 WAIT_FULL: wait until fifo_full=1 -> FETCH; no timeout.
REQ-014 FETCH SHALL last exactly 2 enabled cycles (covers pop-to-data latency), then latch fifo_data into word register -> SEND_HI.
REQ-015 FETCH with fifo_empty=1 in either cycle -> err=1, go IDLE without pop.
REQ-016 SEND_HI presents word[15:8], SEND_LO presents word[7:0]; high byte first.
REQ-017 tx_valid SHALL be 1 only in SEND_HI/SEND_LO/CK_HI/CK_LO; tx_data stable while tx_valid=1 and tx_ready=0; a byte transfers on an enabled edge with tx_valid=tx_ready=1; tx_valid never depends combinationally on tx_ready.
REQ-018 SEND_LO transfer -> POP; POP asserts fifo_rd=1 for exactly one enabled cycle, increments word_cnt.
REQ-019 POP with word_cnt=255: fifo_last must be 1, else err=1 (transfer still completes); then -> CK_HI if checksum compiled in, else DONE; word_cnt wraps to 0.
REQ-020 POP with word_cnt<255 -> FETCH.
REQ-021 DONE: done=1 for one enabled cycle -> IDLE.
REQ-022 busy=1 in every state except IDLE.
REQ-023 abort=1 in any state -> IDLE next enabled edge, tx_valid=0, fifo_rd=0; popped words are not restored; abort outranks start, same-edge tx transfer and pop (no pop on abort edge).
REQ-024 err SHALL hold until next accepted start or reset.

Reset
REQ-025 reset_n=0 at a rising clk edge SHALL apply regardless of clk7_en: state=IDLE, word_cnt=0, checksum=0, fifo_rd=0, tx_valid=0, tx_data=0, busy=0, done=0, err=0.
REQ-026 Reset mid-transfer SHALL abandon the sector with no further pop.

Configuration
REQ-027 Macro GAYLE_SECTOR_CKSUM_EN defined: 16-bit sum mod 2^16 of the 256 latched words sent after data, CK_HI then CK_LO (514 bytes/sector); cleared on accepted start.
REQ-028 Macro undefined: CK_HI/CK_LO and accumulator absent; POP of word 255 -> DONE (512 bytes/sector).

Structure
REQ-029 Shared package gayle_pkg SHALL hold GAYLE_SECTOR_WORDS=256, FETCH latency constant (2), state encoding.
REQ-030 Checksum accumulator SHALL be a sub-module gayle_cksum16 (clear, add, 16-bit sum), instantiated only under GAYLE_SECTOR_CKSUM_EN.

Verification
REQ-031 FIFO with 256 words 0x0000..0x00FF, start, tx_ready=1 -> bytes 00,00,00,01,...,00,FF; 256 fifo_rd pulses; done once; err=0.
REQ-032 Same, tx_ready toggled pseudo-randomly and clk7_en 1-in-4 -> identical byte sequence, tx_data stable while stalled.
REQ-033 start with 255 words loaded -> stays WAIT_FULL, no fifo_rd; 256th word written -> transfer begins.
REQ-034 abort after 100 bytes -> IDLE next enabled edge, tx_valid=0, exactly 50 pops total.
REQ-035 fifo_last forced 0 at word 255 -> err=1, done=1; FIFO emptied at word 10 -> err=1, IDLE, 10 pops.
REQ-036 With GAYLE_SECTOR_CKSUM_EN, all words 0x0101 -> last two bytes 01,00 (sum 0x0100); without it -> 512 bytes then done.
